// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and helpers for the SRAM instruction/data port arbiter.
package mem_bus_arbiter_pkg;

  localparam int unsigned CNT_W   = 4;
  localparam logic [3:0]  SEL_ALL = 4'b1111;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_INST = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_e;

  // Data wins a tie unless it was the last port served.
  function automatic logic pick_data(input logic inst_elig, input logic data_elig,
                                     input grant_e last_grant);
    return data_elig && (!inst_elig || (last_grant != GRANT_DATA));
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_access_timer.sv
// Loadable down-counter timing how long the SRAM is held per access.
module mem_bus_arbiter_access_timer
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Counter register, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single-port SRAM between IF instruction fetch and MEM data access.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_done,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [3:0]        data_sel,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_done,
  output logic              stall_req_if,
  output logic              stall_req_mem,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [3:0]        sram_sel,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  arb_state_e        state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic              inst_done_q, inst_done_d;
  logic              data_done_q, data_done_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              sram_ce_q, sram_ce_d;
  logic              sram_we_q, sram_we_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [3:0]        sram_sel_q, sram_sel_d;
  logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;

  logic tmr_load, tmr_dec, tmr_zero;
  logic inst_elig, data_elig, grant_data;

  // A port finishing this cycle must not be re-granted on its stale request.
  assign inst_elig  = inst_req && !inst_done_q;
  assign data_elig  = data_req && !data_done_q;
  assign grant_data = pick_data(inst_elig, data_elig, last_grant_q);

  mem_bus_arbiter_access_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (CNT_W'(ACCESS_CYCLES - 1)),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Next-state, grant capture and completion logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    inst_done_d  = 1'b0;
    data_done_d  = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    sram_ce_d    = sram_ce_q;
    sram_we_d    = sram_we_q;
    sram_addr_d  = sram_addr_q;
    sram_sel_d   = sram_sel_q;
    sram_wdata_d = sram_wdata_q;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (inst_elig || data_elig) begin
          tmr_load  = 1'b1;
          sram_ce_d = 1'b1;
          if (grant_data) begin
            state_d      = ARB_DATA;
            last_grant_d = GRANT_DATA;
            sram_we_d    = data_we;
            sram_addr_d  = data_addr;
            sram_sel_d   = data_sel;
            sram_wdata_d = data_wdata;
          end else begin
            state_d      = ARB_INST;
            last_grant_d = GRANT_INST;
            sram_we_d    = 1'b0;
            sram_addr_d  = inst_addr;
            sram_sel_d   = SEL_ALL;
            sram_wdata_d = '0;
          end
        end
      end
      ARB_INST: begin
        if (tmr_zero) begin
          inst_rdata_d = sram_rdata;
          inst_done_d  = 1'b1;
          sram_ce_d    = 1'b0;
          sram_we_d    = 1'b0;
          state_d      = ARB_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ARB_DATA: begin
        if (tmr_zero) begin
          if (!sram_we_q) begin
            data_rdata_d = sram_rdata;
          end
          data_done_d = 1'b1;
          sram_ce_d   = 1'b0;
          sram_we_d   = 1'b0;
          state_d     = ARB_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        sram_ce_d = 1'b0;
        sram_we_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GRANT_INST;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      sram_ce_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_sel_q   <= '0;
      sram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      sram_ce_q    <= sram_ce_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_sel_q   <= sram_sel_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  assign inst_rdata    = inst_rdata_q;
  assign inst_done     = inst_done_q;
  assign data_rdata    = data_rdata_q;
  assign data_done     = data_done_q;
  assign sram_ce       = sram_ce_q;
  assign sram_we       = sram_we_q;
  assign sram_addr     = sram_addr_q;
  assign sram_sel      = sram_sel_q;
  assign sram_wdata    = sram_wdata_q;
  assign stall_req_if  = inst_req && !inst_done_q;
  assign stall_req_mem = data_req && !data_done_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a byte-enabled SRAM model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_done;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [3:0]  data_sel;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        stall_req_if;
  logic        stall_req_mem;
  logic        sram_ce;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [3:0]  sram_sel;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:255];

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .ACCESS_CYCLES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_req      (inst_req),
    .inst_addr     (inst_addr),
    .inst_rdata    (inst_rdata),
    .inst_done     (inst_done),
    .data_req      (data_req),
    .data_we       (data_we),
    .data_addr     (data_addr),
    .data_sel      (data_sel),
    .data_wdata    (data_wdata),
    .data_rdata    (data_rdata),
    .data_done     (data_done),
    .stall_req_if  (stall_req_if),
    .stall_req_mem (stall_req_mem),
    .sram_ce       (sram_ce),
    .sram_we       (sram_we),
    .sram_addr     (sram_addr),
    .sram_sel      (sram_sel),
    .sram_wdata    (sram_wdata),
    .sram_rdata    (sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: byte-enabled synchronous write, asynchronous read while enabled.
  assign sram_rdata = (sram_ce && !sram_we) ? mem[sram_addr[9:2]] : 32'h0;

  always @(posedge clk) begin
    if (sram_ce && sram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_sel[b]) mem[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    int          d_cnt;
    int          i_cnt;
    int          ng;
    int          we_viol;
    logic        prev_ce;
    logic [31:0] gaddr [4];

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'h3C01_1234;
    mem[5] = 32'h3421_5678;
    mem[6] = 32'hAC22_0100;
    mem[7] = 32'h8C23_0100;

    rst = 1'b1; inst_req = 1'b1; inst_addr = 32'h0000_0010;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_sel = '0; data_wdata = '0;

    // Reset held three cycles with a pending fetch.
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("rst_ce", sram_ce, 1'b0);
      chk1("rst_idone", inst_done, 1'b0);
    end
    chk("rst_irdata", inst_rdata, 32'h0);
    chk("rst_drdata", data_rdata, 32'h0);
    chk1("rst_stall_if", stall_req_if, 1'b1);
    rst = 1'b0;

    // Instruction read at 0x10.
    step();
    chk1("if1_ce", sram_ce, 1'b1);
    chk1("if1_we", sram_we, 1'b0);
    chk("if1_addr", sram_addr, 32'h0000_0010);
    chk("if1_sel", 32'(sram_sel), 32'hF);
    step();
    chk1("if2_ce", sram_ce, 1'b1);
    chk1("if2_done", inst_done, 1'b0);
    step();
    chk1("if3_ce", sram_ce, 1'b0);
    chk1("if3_done", inst_done, 1'b1);
    chk("if3_rdata", inst_rdata, 32'h3C01_1234);
    chk1("if3_stall", stall_req_if, 1'b0);
    inst_req = 1'b0;
    step();
    chk1("if4_done", inst_done, 1'b0);

    // Partial write to 0x100.
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h0000_0100;
    data_sel = 4'b0011; data_wdata = 32'hDEAD_BEEF;
    step();
    chk1("wr1_ce", sram_ce, 1'b1);
    chk1("wr1_we", sram_we, 1'b1);
    chk("wr1_sel", 32'(sram_sel), 32'h3);
    chk("wr1_wdata", sram_wdata, 32'hDEAD_BEEF);
    step();
    chk1("wr2_we", sram_we, 1'b1);
    chk1("wr2_done", data_done, 1'b0);
    step();
    chk1("wr3_ce", sram_ce, 1'b0);
    chk1("wr3_we", sram_we, 1'b0);
    chk1("wr3_done", data_done, 1'b1);
    chk("wr3_rdata", data_rdata, 32'h0);
    data_req = 1'b0;
    step();
    chk1("wr4_done", data_done, 1'b0);

    // Read back 0x100.
    data_req = 1'b1; data_we = 1'b0; data_sel = 4'b1111;
    step(); step(); step();
    chk1("rd_done", data_done, 1'b1);
    chk("rd_rdata", data_rdata, 32'h0000_BEEF);
    data_req = 1'b0;
    step();

    // Fetch 0x14 so the last grant is INST.
    inst_req = 1'b1; inst_addr = 32'h0000_0014;
    step(); step(); step();
    chk1("if5_done", inst_done, 1'b1);
    chk("if5_rdata", inst_rdata, 32'h3421_5678);
    inst_req = 1'b0;
    step();

    // Simultaneous requests: DATA first, then INST.
    inst_req = 1'b1; inst_addr = 32'h0000_0018;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_0100;
    step();
    chk("sim1_addr", sram_addr, 32'h0000_0100);
    chk1("sim1_stall_if", stall_req_if, 1'b1);
    chk1("sim1_stall_mem", stall_req_mem, 1'b1);
    step();
    chk1("sim2_stall_if", stall_req_if, 1'b1);
    step();
    chk1("sim3_ddone", data_done, 1'b1);
    chk1("sim3_stall_mem", stall_req_mem, 1'b0);
    chk1("sim3_stall_if", stall_req_if, 1'b1);
    data_req = 1'b0;
    step();
    chk1("sim4_ce", sram_ce, 1'b1);
    chk("sim4_addr", sram_addr, 32'h0000_0018);
    chk1("sim4_stall_if", stall_req_if, 1'b1);
    step();
    chk1("sim5_stall_if", stall_req_if, 1'b1);
    step();
    chk1("sim6_idone", inst_done, 1'b1);
    chk("sim6_rdata", inst_rdata, 32'hAC22_0100);
    chk1("sim6_stall_if", stall_req_if, 1'b0);
    inst_req = 1'b0;
    step();

    // Back-to-back loads with a pending fetch: DATA, INST, DATA, INST.
    d_cnt = 0; i_cnt = 0; ng = 0; we_viol = 0; prev_ce = sram_ce;
    for (int i = 0; i < 4; i++) gaddr[i] = 32'h0;
    data_req = 1'b1; data_addr = 32'h0000_0100;
    inst_req = 1'b1; inst_addr = 32'h0000_001C;
    for (int c = 0; c < 40 && (data_req || inst_req); c++) begin
      step();
      if (sram_ce && !prev_ce && ng < 4) begin
        gaddr[ng] = sram_addr;
        ng++;
      end
      if (sram_ce && sram_we) we_viol++;
      prev_ce = sram_ce;
      if (data_done) begin
        d_cnt++;
        if (d_cnt == 3) data_req = 1'b0;
      end
      if (inst_done) begin
        i_cnt++;
        if (i_cnt == 2) inst_req = 1'b0;
      end
    end
    chk("b2b_ngrants", 32'(ng), 32'd4);
    chk("b2b_g0", gaddr[0], 32'h0000_0100);
    chk("b2b_g1", gaddr[1], 32'h0000_001C);
    chk("b2b_g2", gaddr[2], 32'h0000_0100);
    chk("b2b_g3", gaddr[3], 32'h0000_001C);
    chk("b2b_dcnt", 32'(d_cnt), 32'd3);
    chk("b2b_icnt", 32'(i_cnt), 32'd2);
    chk("b2b_we", 32'(we_viol), 32'd0);
    chk("b2b_irdata", inst_rdata, 32'h8C23_0100);
    step();

    // Address change mid-access is ignored.
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_0100; data_sel = 4'b1111;
    step();
    chk("cap1_addr", sram_addr, 32'h0000_0100);
    data_addr = 32'h0000_0200; data_sel = 4'b0000;
    step();
    chk("cap2_addr", sram_addr, 32'h0000_0100);
    chk("cap2_sel", 32'(sram_sel), 32'hF);
    step();
    chk1("cap3_done", data_done, 1'b1);
    chk("cap3_rdata", data_rdata, 32'h0000_BEEF);
    data_req = 1'b0;
    step();

    // Reset in the middle of a data write, then re-issue.
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h0000_0104;
    data_sel = 4'b1111; data_wdata = 32'h1234_5678;
    step();
    chk1("ra1_ce", sram_ce, 1'b1);
    rst = 1'b1;
    step();
    chk1("ra2_ce", sram_ce, 1'b0);
    chk1("ra2_ddone", data_done, 1'b0);
    chk1("ra2_idone", inst_done, 1'b0);
    chk("ra2_drdata", data_rdata, 32'h0);
    rst = 1'b0;
    step();
    chk1("ra3_ce", sram_ce, 1'b1);
    chk1("ra3_we", sram_we, 1'b1);
    chk("ra3_addr", sram_addr, 32'h0000_0104);
    step();
    step();
    chk1("ra5_ddone", data_done, 1'b1);
    data_req = 1'b0;
    step();
    data_req = 1'b1; data_we = 1'b0;
    step(); step(); step();
    chk1("ra_rd_done", data_done, 1'b1);
    chk("ra_rd_rdata", data_rdata, 32'h1234_5678);
    data_req = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
